// File: rtl/ysyx_22040088_lsu_ctrl.sv
// Load/store sequencer: latches one access, issues one aligned bus request,
// waits for the response and returns extended load data or a fault.
// Ports: clk/rst; decode side mem_ena, mem_wen, mem_mask, ld_unsigned, addr,
// wdata; core side stall, done, ld_data, fault; bus side req_* / resp_*.
module ysyx_22040088_lsu_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ena,
    input  logic        mem_wen,
    input  logic [3:0]  mem_mask,
    input  logic        ld_unsigned,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [63:0] ld_data,
    output logic        fault,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    output logic        req_wen,
    output logic [7:0]  req_wstrb,
    output logic [63:0] req_wdata,
    input  logic        resp_valid,
    input  logic [63:0] resp_rdata,
    input  logic        resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       addr_r, wdata_r, rdata_r;
    logic [3:0]        mask_r;
    logic              wen_r, uns_r, fault_r;

    logic              bad_in, mis_in, to_hit;
    logic [2:0]        off_r;
    logic [7:0]        strb_base;
    logic [63:0]       sh, ext;

    // Access check on the incoming request (mask may be corrupt).
    always_comb begin
        bad_in = 1'b0;
        mis_in = 1'b0;
        case (mem_mask)
            4'b0001: mis_in = addr[2:0] != 3'd0;
            4'b0010: mis_in = addr[1:0] != 2'd0;
            4'b0100: mis_in = addr[0];
            4'b1000: mis_in = 1'b0;
            default: bad_in = 1'b1;
        endcase
    end

    // Last allowed cycle in REQ+WAIT: counter reaches TIMEOUT after it.
    assign to_hit = (TIMEOUT > 0) && (cnt == TO_LAST);
    assign off_r  = addr_r[2:0];
    assign sh     = rdata_r >> {off_r, 3'b000};

    always_comb begin
        strb_base = 8'h00;
        ext       = 64'd0;
        case (mask_r)
            4'b0001: begin
                strb_base = 8'hFF;
                ext       = sh;
            end
            4'b0010: begin
                strb_base = 8'h0F;
                ext = {{32{sh[31] & ~uns_r}}, sh[31:0]};
            end
            4'b0100: begin
                strb_base = 8'h03;
                ext = {{48{sh[15] & ~uns_r}}, sh[15:0]};
            end
            4'b1000: begin
                strb_base = 8'h01;
                ext = {{56{sh[7] & ~uns_r}}, sh[7:0]};
            end
            default: begin
                strb_base = 8'h00;
                ext       = 64'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (mem_ena) state_n = (mis_in | bad_in) ? DONE : REQ;
            REQ: begin
                // An abandoned request is acceptable to the bus.
                if (to_hit)         state_n = DONE;
                else if (req_ready) state_n = WAIT;
            end
            WAIT: if (resp_valid | to_hit) state_n = DONE;
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            mask_r  <= '0;
            wen_r   <= 1'b0;
            uns_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (mem_ena) begin
                    addr_r  <= addr;
                    wdata_r <= wdata;
                    mask_r  <= mem_mask;
                    wen_r   <= mem_wen;
                    uns_r   <= ld_unsigned;
                    rdata_r <= '0;
                    fault_r <= mis_in | bad_in;
                    cnt     <= '0;
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (to_hit) fault_r <= 1'b1;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (resp_valid) begin
                        rdata_r <= resp_rdata;
                        fault_r <= resp_err;
                    end else if (to_hit) begin
                        fault_r <= 1'b1;
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign stall     = (state == IDLE && mem_ena) ||
                       state == REQ || state == WAIT;
    assign req_valid = state == REQ;
    assign req_addr  = req_valid ? {addr_r[63:3], 3'b000} : 64'd0;
    assign req_wen   = req_valid & wen_r;
    assign req_wstrb = req_valid ? strb_base << off_r : 8'h00;
    assign req_wdata = req_valid ? wdata_r << {off_r, 3'b000} : 64'd0;
    assign done      = state == DONE;
    assign fault     = done & fault_r;
    assign ld_data   = (done && !wen_r && !fault_r) ? ext : 64'd0;

endmodule
